// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
package display_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         MAX_DIGITS = 16;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/lz_blank_mask.sv
// Per-digit blank vector: masked digits, plus leading zeros above digit 0
// found with a prefix-OR of nonzero flags running from the MSB down.
module lz_blank_mask #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] active_i,
  input  logic [NUM_DIGITS-1:0]   digit_mask_i,
  input  logic                    lz_blank_en_i,
  output logic [NUM_DIGITS-1:0]   blank_o
);

  logic seen_nonzero;

  // NOTE: blocking assignments here are deliberate; seen_nonzero must carry
  // the running OR from one loop iteration into the next.
  always_comb begin
    seen_nonzero = 1'b0;
    blank_o      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nonzero = seen_nonzero | (|active_i[4*i +: 4]);
      blank_o[i]   = ~digit_mask_i[i] | (lz_blank_en_i & (i != 0) & ~seen_nonzero);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Double-buffered digit scanner: dwell/gap FSM, shadow/active buffers and
// registered digit select and code outputs for a shared 7-segment decoder.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic                    lz_blank_en,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [3:0]              digit_code_q, digit_code_d;
  logic                    frame_start_q, frame_start_d;

  logic                    lit_phase;
  logic                    frame_pulse;
  logic [NUM_DIGITS-1:0]   blank;

  // NOTE: every variable gets a default before the case/if logic so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    if (!en) begin
      state_d = GAP;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = SCAN;
            cnt_d   = '0;
          end
        end
        SCAN: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
        end
        default: begin
          state_d = GAP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs trail the FSM by one register, so a window starts on the edge
  // after SCAN is entered; that edge is also the frame boundary for buffers.
  assign lit_phase   = en && (state_q == SCAN);
  assign frame_pulse = lit_phase && (idx_q == '0) && (cnt_q == '0);

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end
    if (frame_pulse) begin
      if (load)           active_d = digits_in;
      else if (pending_q) active_d = shadow_q;
      pending_d = 1'b0;
    end
  end

  lz_blank_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_blank_mask (
    .active_i      (active_d),
    .digit_mask_i  (digit_mask),
    .lz_blank_en_i (lz_blank_en),
    .blank_o       (blank)
  );

  always_comb begin
    digit_sel_d   = '0;
    digit_code_d  = BLANK_CODE;
    frame_start_d = frame_pulse;
    if (lit_phase && !blank[idx_q]) begin
      digit_sel_d  = NUM_DIGITS'(onehot(4'(idx_q)));
      digit_code_d = active_d[{idx_q, 2'b00} +: 4];
    end
  end

  // NOTE: non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= GAP;
      idx_q         <= '0;
      cnt_q         <= '0;
      // NOTE: the digit buffers are reset on purpose: after reset the
      // display must show zeros, never stale contents.
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      digit_sel_q   <= '0;
      digit_code_q  <= BLANK_CODE;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      digit_sel_q   <= digit_sel_d;
      digit_code_q  <= digit_code_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign digit_sel   = digit_sel_q;
  assign digit_code  = digit_code_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux (4 digits, dwell 4, gap 2).
module tb_display_scan_mux;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int GP = 2;
  localparam int SLOT  = DW + GP;
  localparam int FRAME = SLOT * N;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  digit_mask;
  logic        lz_blank_en;
  logic [3:0]  digit_code;
  logic [3:0]  digit_sel;
  logic        frame_start;

  always #5 clk = ~clk;

  display_scan_mux #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DW),
    .GAP_CYCLES   (GP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .load        (load),
    .digits_in   (digits_in),
    .digit_mask  (digit_mask),
    .lz_blank_en (lz_blank_en),
    .digit_code  (digit_code),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] code;
    logic       fs;
  } exp_t;

  exp_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "reset";

  // Timing/buffer model state: edges since scanning (re)started, buffers.
  int          m_k;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_pending;
  int          last_slot = -1;
  int          last_pos  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_blank(input logic [15:0] act, input logic [3:0] mask,
                                     input logic lz, input int i);
    if (!mask[i]) return 1'b1;
    if (lz && i > 0) begin
      for (int j = i; j < N; j++)
        if (act[4*j +: 4] != 4'h0) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Predict outputs after the coming edge from current inputs, push, then clock.
  task automatic tick();
    exp_t e;
    int   t, slot, pos;
    logic lit, bnd;
    e    = '{sel: 4'h0, code: 4'hF, fs: 1'b0};
    lit  = 1'b0;
    bnd  = 1'b0;
    slot = 0;
    pos  = 0;
    if (!rst_n) begin
      m_k = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
      last_slot = -1; last_pos = -1;
    end else begin
      if (en) begin
        m_k++;
        t = m_k - (GP + 1);
        if (t >= 0) begin
          slot = (t / SLOT) % N;
          pos  = t % SLOT;
          lit  = (pos < DW);
          bnd  = (slot == 0) && (pos == 0);
          last_slot = slot; last_pos = pos;
        end else begin
          last_slot = -1; last_pos = -1;
        end
      end else begin
        m_k = 0; last_slot = -1; last_pos = -1;
      end
      if (bnd) begin
        if (load)           m_active = digits_in;
        else if (m_pending) m_active = m_shadow;
        m_pending = 1'b0;
      end
      if (load) begin
        m_shadow = digits_in;
        if (!bnd) m_pending = 1'b1;
      end
      e.fs = bnd;
      if (lit && !exp_blank(m_active, digit_mask, lz_blank_en, slot)) begin
        e.sel  = 4'(1 << slot);
        e.code = m_active[4*slot +: 4];
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int slot, input int pos);
    bit hit = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (last_slot == slot && last_pos == pos) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) check("run_to_timeout", 32'(last_pos), 32'(pos));
  endtask

  task automatic load_val(input logic [15:0] v);
    digits_in = v;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(phase, 32'({digit_sel, digit_code, frame_start}), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; digits_in = 16'h4321;
    digit_mask = 4'hF; lz_blank_en = 1'b0;
    m_k = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;

    phase = "reset";
    tick(); tick();

    phase = "sequence";
    rst_n = 1'b1;
    load_val(16'h4321);
    repeat (2 * FRAME) tick();

    phase = "lz_0050";
    lz_blank_en = 1'b1;
    load_val(16'h0050);
    repeat (2 * FRAME) tick();

    phase = "lz_0000";
    load_val(16'h0000);
    repeat (2 * FRAME) tick();

    phase = "mask";
    lz_blank_en = 1'b0;
    digit_mask  = 4'b1010;
    load_val(16'h9999);
    repeat (2 * FRAME) tick();

    phase = "tear_free";
    digit_mask = 4'hF;
    load_val(16'h1111);
    run_to(N - 1, SLOT - 1);
    tick();
    run_to(2, 1);
    load_val(16'h2222);
    repeat (2 * FRAME) tick();

    phase = "load_at_frame";
    run_to(N - 1, SLOT - 1);
    load_val(16'h5678);
    repeat (FRAME) tick();

    phase = "en_drop";
    run_to(1, 1);
    en = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    repeat (FRAME + 6) tick();

    phase = "rst_mid";
    run_to(1, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (FRAME + 6) tick();

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
